mul_fixed: RTL and testbench
============================

// Module: mul_fixed
// PURPOSE
//  Sequential signed fixed-point multiplier: val = a*b, rounded half-to-even.
//  Shift-add core; one multiplier bit per cycle. Companion to the fixed-point divider.
//  Shares the divider's start/busy/done/valid/ovf handshake so the datapath sequencer
//  drives both blocks the same way.
// PARAMETERS
//  WIDTH  32  total operand/result width in bits, two's complement
//  FBITS  16  fractional bits within WIDTH (0 <= FBITS < WIDTH)
// PORTS
//  clk    in   1      clock
//  rst    in   1      synchronous, active-high reset
//  start  in   1      begin calculation; sampled only in IDLE
//  busy   out  1      calculation in progress
//  done   out  1      one-cycle pulse at completion, including ovf aborts
//  valid  out  1      val holds a good result
//  ovf    out  1      result or operand out of range
//  a      in   WIDTH  signed multiplicand, Q(WIDTH-1-FBITS).FBITS
//  b      in   WIDTH  signed multiplier, same format
//  val    out  WIDTH  signed product, same format
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, valid, ovf = 0; val = 0. rst wins over every other event.
//  Reset mid-operation: calculation discarded; no done pulse.
//  WU = WIDTH-1. SMALLEST = {1,0...}.
//  States: IDLE -> CALC -> ROUND -> SIGN -> IDLE.
//  IDLE, start=1, a or b == SMALLEST: next cycle done=1, ovf=1, valid=0, busy=0; val unchanged.
//  IDLE, start=1, otherwise:
//    register au=|a|, bu=|b| (WU bits each) and sneg = a_sign ^ b_sign
//    clear prod (2*WU bits) and i; busy=1, valid=0, ovf=0
//  CALC (WU cycles, i = 0..WU-1): if bu[i], prod += au << i. Leave at i == WU-1.
//  ROUND, inputs:
//    lsb    = prod[FBITS]
//    guard  = prod[FBITS-1]
//    sticky = |prod[FBITS-2:0]
//    Tie bits absent when FBITS < 2; FBITS = 0 means no rounding.
//  ROUND, action:
//    mag = (prod >> FBITS) + (guard & (lsb | sticky))
//    If mag >= 2^WU: IDLE, done=1, ovf=1, busy=0, valid=0; val unchanged.
//  SIGN:
//    val = sneg ? -mag : mag; mag == 0 gives val=0 (never negative zero)
//    done=1, valid=1, busy=0
//  Latency: done is high in the cycle after the WU+2nd edge following the start-sampling
//  edge (33 edges for WIDTH=32).
//  start while busy is ignored. a/b are sampled only at start; later changes have no effect.
//  done never lasts more than one cycle. valid/val hold until the next accepted start
//  or rst. ovf holds until the next accepted start or rst.
// STRUCTURE
//  Shared package fixed_pkg holds:
//    calc_state_t enum {IDLE, INIT, CALC, ROUND, SIGN}, shared with the divider
//    function fx_smallest(WIDTH)
//    function fx_round_even(lsb, guard, sticky)
//  No sub-module: core and FSM in one always_ff, with the add-step and rounding in always_comb.
//  Counter i is $clog2(WU)+1 bits.
// TESTING (WIDTH=32, FBITS=16)
//  3.0*2.5: a=32'h0003_0000, b=32'h0002_8000 -> val=32'h0007_8000, valid=1, ovf=0, done at edge 33
//  -1.5*2.0: a=32'hFFFE_8000, b=32'h0002_0000 -> val=32'hFFFD_0000;
//    -1.5*-1.5 -> 32'h0002_4000
//  Rounding, b=32'h0000_8000:
//    a=32'h1 -> val=0 (tie, even)
//    a=32'h3 -> val=32'h2 (tie, odd rounds up)
//    a=32'h1 with b=32'h0000_C000 -> val=32'h1
//  Overflow:
//    a=b=32'h0100_0000 -> done=1, ovf=1, valid=0, val unchanged
//    a=32'h8000_0000 -> ovf, done on the next edge
//  Zero: a=0, b=32'hFFFB_0000 -> val=0, valid=1
//    32'h7FFF_FFFF * 32'h0001_0000 -> val=32'h7FFF_FFFF, no ovf
//  Control:
//    rst 10 cycles into CALC -> busy=0 next edge, no done
//    start pulsed while busy -> ignored
//    back-to-back starts -> both results correct

Source files
------------

// File: rtl/fixed_pkg.sv
// fixed_pkg: shared state encoding and helpers for the fixed-point multiplier and divider
// calc_state_t  sequencer states common to both blocks
// fx_smallest   most negative two's complement value for a given width
// fx_round_even round-half-to-even increment from lsb, guard and sticky bits
package fixed_pkg;
  typedef enum logic [2:0] {IDLE, INIT, CALC, ROUND, SIGN} calc_state_t;
  function automatic logic [63:0] fx_smallest(input int w);
    return 64'd1 << (w - 1);
  endfunction
  function automatic logic fx_round_even(input logic lsb, input logic guard, input logic sticky);
    return guard & (lsb | sticky);
  endfunction
endpackage

// File: rtl/mul_fixed_if.sv
// mul_fixed_if: start/busy/done/valid/ovf handshake plus operand and result buses
// master: drives start, a, b; reads busy, done, valid, ovf, val
// slave:  the calculation block
interface mul_fixed_if #(parameter int WIDTH = 32);
  logic start, busy, done, valid, ovf;
  logic [WIDTH-1:0] a, b, val;
  modport master(output start, a, b, input busy, done, valid, ovf, val);
  modport slave(input start, a, b, output busy, done, valid, ovf, val);
endinterface

// File: rtl/mul_fixed.sv
// mul_fixed: sequential signed fixed-point multiplier, shift-add, round half-to-even
// clk, rst  clock and synchronous active-high reset
// bus       slave side of mul_fixed_if: start/a/b in; busy/done/valid/ovf/val out
module mul_fixed import fixed_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input logic clk,
  input logic rst,
  mul_fixed_if.slave bus
);
  localparam int WU = WIDTH - 1;
  localparam int IW = $clog2(WU) + 1;
  localparam int PW = 2 * WU;
  localparam logic [WIDTH-1:0] SMALLEST = WIDTH'(fx_smallest(WIDTH));
  calc_state_t state;
  logic [WU-1:0] au, bu, mag;
  logic [PW-1:0] prod, prod_add;
  logic [PW:0] mag_full;
  logic [IW-1:0] i;
  logic sneg, lsb, guard, sticky, too_big;
  // Tie-breaking bits only exist when there are enough fractional bits
  if (FBITS == 0) begin : g_nornd
    assign lsb = 1'b0;
    assign guard = 1'b0;
    assign sticky = 1'b0;
  end else if (FBITS == 1) begin : g_rnd1
    assign lsb = prod[FBITS];
    assign guard = prod[0];
    assign sticky = 1'b0;
  end else begin : g_rnd
    assign lsb = prod[FBITS];
    assign guard = prod[FBITS-1];
    assign sticky = |prod[FBITS-2:0];
  end
  always_comb begin
    prod_add = bu[i] ? prod + (PW'(au) << i) : prod;
    mag_full = (PW+1)'(prod >> FBITS) + (PW+1)'(fx_round_even(lsb, guard, sticky));
    too_big = |mag_full[PW:WU];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.valid <= 1'b0;
      bus.ovf <= 1'b0;
      bus.val <= '0;
      au <= '0;
      bu <= '0;
      mag <= '0;
      prod <= '0;
      i <= '0;
      sneg <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bus.valid <= 1'b0;
          if (bus.a == SMALLEST || bus.b == SMALLEST) begin
            bus.done <= 1'b1;
            bus.ovf <= 1'b1;
          end else begin
            // Low WU bits of the negation equal |x| because SMALLEST is excluded
            au <= bus.a[WU] ? -bus.a[WU-1:0] : bus.a[WU-1:0];
            bu <= bus.b[WU] ? -bus.b[WU-1:0] : bus.b[WU-1:0];
            sneg <= bus.a[WU] ^ bus.b[WU];
            prod <= '0;
            i <= '0;
            bus.busy <= 1'b1;
            bus.ovf <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          prod <= prod_add;
          i <= i + 1'b1;
          if (i == IW'(WU - 1)) state <= ROUND;
        end
        ROUND: if (too_big) begin
          bus.done <= 1'b1;
          bus.ovf <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end else begin
          mag <= mag_full[WU-1:0];
          state <= SIGN;
        end
        SIGN: begin
          bus.val <= sneg ? -{1'b0, mag} : {1'b0, mag};
          bus.done <= 1'b1;
          bus.valid <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_fixed.sv
// tb_mul_fixed: scoreboard bench for mul_fixed at WIDTH=32, FBITS=16
module tb_mul_fixed;
  typedef struct packed {
    logic [31:0] val;
    logic valid, ovf;
    logic [7:0] lat;
  } exp_t;
  typedef struct packed {
    logic [31:0] a, b, val;
    logic valid, ovf;
    logic [7:0] lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int errors = 0, checks = 0;
  logic [31:0] cur_val = '0;
  exp_t sb[$];
  vec_t dir[10] = '{
    '{32'h0003_0000, 32'h0002_8000, 32'h0007_8000, 1'b1, 1'b0, 8'd33},
    '{32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 1'b1, 1'b0, 8'd33},
    '{32'hFFFE_8000, 32'hFFFE_8000, 32'h0002_4000, 1'b1, 1'b0, 8'd33},
    '{32'h0000_0001, 32'h0000_8000, 32'h0000_0000, 1'b1, 1'b0, 8'd33},
    '{32'h0000_0003, 32'h0000_8000, 32'h0000_0002, 1'b1, 1'b0, 8'd33},
    '{32'h0000_0001, 32'h0000_C000, 32'h0000_0001, 1'b1, 1'b0, 8'd33},
    '{32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 1'b0, 1'b1, 8'd32},
    '{32'h8000_0000, 32'h0003_0000, 32'h0000_0000, 1'b0, 1'b1, 8'd0},
    '{32'h0000_0000, 32'hFFFB_0000, 32'h0000_0000, 1'b1, 1'b0, 8'd33},
    '{32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 8'd33}
  };
  always #5 clk = ~clk;
  mul_fixed_if #(.WIDTH(32)) bus();
  mul_fixed #(.WIDTH(32), .FBITS(16)) dut(.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_res(input logic [31:0] val, input logic valid, input logic ovf, input logic [7:0] lat);
    exp_t e;
    if (valid) cur_val = val;
    e = '{cur_val, valid, ovf, lat};
    sb.push_back(e);
  endtask
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] au, bu, v;
    logic [63:0] p, m;
    logic r;
    e = '{32'h0, 1'b0, 1'b1, 8'd0};
    if (a == 32'h8000_0000 || b == 32'h8000_0000) return e;
    au = a[31] ? -a : a;
    bu = b[31] ? -b : b;
    p = {32'h0, au} * {32'h0, bu};
    r = p[15] & (p[16] | (|p[14:0]));
    m = (p >> 16) + 64'(r);
    if (m >= 64'h8000_0000) begin
      e.lat = 8'd32;
      return e;
    end
    v = m[31:0];
    if (a[31] ^ b[31]) v = -v;
    e = '{v, 1'b1, 1'b0, 8'd33};
    return e;
  endfunction
  // Called with the DUT idle, #1 after a clock edge
  task automatic op(input logic [31:0] a, input logic [31:0] b, input bit poke, input bit gap);
    exp_t e;
    int n;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = ~a;
    bus.b = 32'h0001_2345;
    n = 0;
    while (!bus.done && n < 100) begin
      bus.start = poke && n == 5;
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    check("latency", 64'(n), 64'(e.lat));
    check("val", 64'(bus.val), 64'(e.val));
    check("valid", 64'(bus.valid), 64'(e.valid));
    check("ovf", 64'(bus.ovf), 64'(e.ovf));
    check("busy_end", 64'(bus.busy), 64'd0);
    if (gap) begin
      @(posedge clk);
      #1;
      check("done_pulse", 64'(bus.done), 64'd0);
    end
  endtask
  initial begin
    int dones;
    logic [31:0] ra, rb;
    exp_t e;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    check("rst_val", 64'(bus.val), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    foreach (dir[k]) begin
      expect_res(dir[k].val, dir[k].valid, dir[k].ovf, dir[k].lat);
      op(dir[k].a, dir[k].b, 1'b0, 1'b1);
    end
    expect_res(32'h0007_8000, 1'b1, 1'b0, 8'd33);
    op(32'h0003_0000, 32'h0002_8000, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      ra = 32'($urandom_range(0, 2097151)) - 32'h0010_0000;
      rb = 32'($urandom_range(0, 2097151)) - 32'h0010_0000;
      e = model(ra, rb);
      expect_res(e.val, e.valid, e.ovf, e.lat);
      op(ra, rb, 1'b0, k[0]);
    end
    bus.a = 32'h0003_0000;
    bus.b = 32'h0002_0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_valid", 64'(bus.valid), 64'd0);
    check("midrst_val", 64'(bus.val), 64'd0);
    cur_val = '0;
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("midrst_nodone", 64'(dones), 64'd0);
    expect_res(32'hFFFD_0000, 1'b1, 1'b0, 8'd33);
    op(32'hFFFE_8000, 32'h0002_0000, 1'b0, 1'b0);
    expect_res(32'h0002_4000, 1'b1, 1'b0, 8'd33);
    op(32'hFFFE_8000, 32'hFFFE_8000, 1'b0, 1'b1);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
